hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard and flush controller.
- Produces the stall/bubble controls consumed by the PC, IF/ID and ID/EX registers: `hazard`, `BranchBubble`, `cp0bubble`.
- Detects load-use hazards in ID/EX.
- Sequences multi-cycle MDU (mult/div) stalls and CP0 exception/eret flushes with an internal FSM and counter.
- Sits beside the ID stage; inputs come from the decoder and the EX stage.

Parameters:
- MDU_CYCLES, 4, stall cycles per mult/div issue (>=1).
- EXC_FLUSH_CYCLES, 2, cycles of pipeline squash after syscall/eret (>=1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- id_ra  in  5  ID source register A
- id_rb  in  5  ID source register B
- id_useA  in  1  ID instruction reads ra
- id_useB  in  1  ID instruction reads rb
- ex_rw  in  5  EX destination register
- ex_regWr  in  1  EX writes the register file
- ex_memtoreg  in  2  EX writeback select; LOAD=2'd1
- ex_branch_taken  in  1  branch resolved taken in EX
- ex_jump_taken  in  1  j/jal/jalr in EX
- ex_mdu_start  in  1  mult/div issued in EX
- ex_cp0op  in  3  EX CP0 op; ERET=3'b011, SYSCALL=3'b100
- pc_stall  out  1  hold the PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID to nop
- hazard  out  1  bubble ID/EX controls
- BranchBubble  out  1  bubble ID/EX on control transfer
- cp0bubble  out  2  2'd1 = squash ex_cp0op; 2'd0 = none
- mdu_busy  out  1  MDU stall in progress

Behaviour:
- State and timing:
  - States: RUN, MDU_WAIT, EXC_FLUSH.
  - Registers: 2-bit state and a down-counter of width $clog2(max(MDU_CYCLES, EXC_FLUSH_CYCLES)+1).
  - All outputs are combinational from state plus current inputs, so a bubble takes effect at the next clk edge (zero-cycle decision latency).
- Reset (rst_n low, asynchronous): state=RUN, cnt=0. With idle inputs every output is 0. Reset asserted mid-MDU or mid-flush aborts immediately to RUN.
- load_use = ex_regWr & (ex_memtoreg==LOAD) & (ex_rw!=0) & ((id_useA & id_ra==ex_rw) | (id_useB & id_rb==ex_rw)).
- RUN, in priority order:
  1. exc = ex_cp0op in {ERET, SYSCALL}: next EXC_FLUSH, cnt=EXC_FLUSH_CYCLES-1. This cycle: cp0bubble=1, ifid_flush=1, hazard=1.
  2. xfer = ex_branch_taken | ex_jump_taken: BranchBubble=1, ifid_flush=1. No stall; a simultaneous load_use is ignored because the ID instruction is wrong-path.
  3. ex_mdu_start: next MDU_WAIT, cnt=MDU_CYCLES-1. This cycle: pc_stall=ifid_stall=hazard=mdu_busy=1.
  4. load_use: pc_stall=ifid_stall=hazard=1 for exactly one cycle. The next cycle re-evaluates with the bubble in EX, so load_use drops.
  - If ex_mdu_start and xfer coincide: xfer outputs are asserted and the FSM still enters MDU_WAIT.
- MDU_WAIT:
  - pc_stall=ifid_stall=hazard=mdu_busy=1.
  - cnt decrements each cycle; when cnt==0, next RUN.
  - EX inputs are ignored (EX holds a bubble).
  - MDU_CYCLES=1 gives exactly one stall cycle in total (the RUN issue cycle) and no MDU_WAIT cycles.
- EXC_FLUSH:
  - cp0bubble=1, ifid_flush=1, hazard=1, pc_stall=0 (the PC loads the handler/EPC).
  - cnt decrements; when cnt==0, next RUN.
  - A new exc arriving in EXC_FLUSH is ignored.
- Invariants:
  - ifid_stall and ifid_flush are never both 1.
  - pc_stall=1 implies hazard=1.
  - cp0bubble is only ever 0 or 1.

Decomposition:
- Shared package `pipe_ctrl_pkg` holds:
  - MEMTOREG_LOAD = 2'd1
  - CP0OP_ERET = 3'b011, CP0OP_SYSCALL = 3'b100, CP0OP_NONE = 3'b000
  - state enum {RUN, MDU_WAIT, EXC_FLUSH}
- One sub-module is natural: `load_use_detect`, purely combinational, producing load_use.
- FSM and counter stay in hazard_ctrl.

Test Plan:
- Load-use: ex_regWr=1, ex_memtoreg=1, ex_rw=5, id_ra=5, id_useA=1 -> hazard=pc_stall=ifid_stall=1 for 1 cycle. Repeating with ex_rw=0 gives no stall.
- Branch and load-use together: ex_branch_taken=1 with a load_use match -> BranchBubble=1, ifid_flush=1, pc_stall=0, hazard=0.
- MDU: ex_mdu_start pulse with MDU_CYCLES=4 -> mdu_busy=hazard=pc_stall=1 for exactly 4 cycles, then all 0. EX inputs toggled during the stall are ignored.
- Syscall: ex_cp0op=3'b100 -> cp0bubble=1, ifid_flush=1, hazard=1 for 2 cycles; ifid_stall stays 0.
- Priority: ex_cp0op=ERET, ex_jump_taken=1 and ex_mdu_start=1 in the same cycle -> EXC_FLUSH entered, MDU_WAIT never entered, mdu_busy stays 0.
- Reset mid-MDU: rst_n pulled low in cycle 2 of MDU_WAIT -> all outputs 0 immediately without a clk edge; after release, idle inputs give no stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control blocks: writeback select,
// CP0 operation codes and the hazard controller state.
package pipe_ctrl_pkg;

    localparam logic [1:0] MEMTOREG_LOAD = 2'd1;

    localparam logic [2:0] CP0OP_NONE    = 3'b000;
    localparam logic [2:0] CP0OP_ERET    = 3'b011;
    localparam logic [2:0] CP0OP_SYSCALL = 3'b100;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU_WAIT  = 2'd1,
        EXC_FLUSH = 2'd2
    } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_useA,
    input  logic       id_useB,
    input  logic [4:0] ex_rw,
    input  logic       ex_regWr,
    input  logic [1:0] ex_memtoreg,
    output logic       load_use
);

    // $zero is never a real dependency
    assign load_use = ex_regWr && (ex_memtoreg == MEMTOREG_LOAD) && (ex_rw != 5'd0) &&
                      ((id_useA && (id_ra == ex_rw)) || (id_useB && (id_rb == ex_rw)));

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use bubbles, control-transfer flushes,
// multi-cycle MDU stalls and CP0 exception/eret squashes.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES       = 4,
    parameter int EXC_FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_ra,
    input  logic [4:0] id_rb,
    input  logic       id_useA,
    input  logic       id_useB,
    input  logic [4:0] ex_rw,
    input  logic       ex_regWr,
    input  logic [1:0] ex_memtoreg,
    input  logic       ex_branch_taken,
    input  logic       ex_jump_taken,
    input  logic       ex_mdu_start,
    input  logic [2:0] ex_cp0op,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_flush,
    output logic       hazard,
    output logic       BranchBubble,
    output logic [1:0] cp0bubble,
    output logic       mdu_busy
);

    localparam int MAX_CYC = (MDU_CYCLES > EXC_FLUSH_CYCLES) ? MDU_CYCLES : EXC_FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXC_LOAD = CNT_W'(EXC_FLUSH_CYCLES - 1);

    hz_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use, exc, xfer;

    load_use_detect u_lud (
        .id_ra      (id_ra),
        .id_rb      (id_rb),
        .id_useA    (id_useA),
        .id_useB    (id_useB),
        .ex_rw      (ex_rw),
        .ex_regWr   (ex_regWr),
        .ex_memtoreg(ex_memtoreg),
        .load_use   (load_use)
    );

    assign exc  = (ex_cp0op == CP0OP_ERET) || (ex_cp0op == CP0OP_SYSCALL);
    assign xfer = ex_branch_taken || ex_jump_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt holds the stall cycles still owed after the current one; the RUN
    // cycle that triggers a sequence is itself the first squashed cycle.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        hazard       = 1'b0;
        BranchBubble = 1'b0;
        cp0bubble    = 2'd0;
        mdu_busy     = 1'b0;
        case (state)
            RUN: begin
                if (exc) begin
                    cp0bubble  = 2'd1;
                    ifid_flush = 1'b1;
                    hazard     = 1'b1;
                    if (EXC_FLUSH_CYCLES > 1) begin
                        state_nxt = EXC_FLUSH;
                        cnt_nxt   = EXC_LOAD;
                    end
                end else begin
                    if (xfer) begin
                        BranchBubble = 1'b1;
                        ifid_flush   = 1'b1;
                    end
                    if (ex_mdu_start) begin
                        // a flushing transfer owns IF/ID this cycle; the stall starts next cycle
                        if (!xfer) begin
                            pc_stall   = 1'b1;
                            ifid_stall = 1'b1;
                            hazard     = 1'b1;
                            mdu_busy   = 1'b1;
                        end
                        if (MDU_CYCLES > 1) begin
                            state_nxt = MDU_WAIT;
                            cnt_nxt   = MDU_LOAD;
                        end
                    end else if (load_use && !xfer) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        hazard     = 1'b1;
                    end
                end
            end
            MDU_WAIT: begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                hazard     = 1'b1;
                mdu_busy   = 1'b1;
                cnt_nxt    = cnt - 1'b1;
                if (cnt_nxt == '0) state_nxt = RUN;
            end
            EXC_FLUSH: begin
                cp0bubble  = 2'd1;
                ifid_flush = 1'b1;
                hazard     = 1'b1;
                cnt_nxt    = cnt - 1'b1;
                if (cnt_nxt == '0) state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic
// against a remaining-cycles reference model.
module tb_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int MDU_CYCLES       = 4;
    localparam int EXC_FLUSH_CYCLES = 2;

    typedef struct packed {
        logic [4:0] ra;
        logic [4:0] rb;
        logic       useA;
        logic       useB;
        logic [4:0] rw;
        logic       regWr;
        logic [1:0] memtoreg;
        logic       br;
        logic       jmp;
        logic       mdu;
        logic [2:0] cp0op;
    } stim_t;

    typedef struct {
        logic [7:0] exp;
        string      tag;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] id_ra = '0, id_rb = '0, ex_rw = '0;
    logic id_useA = 0, id_useB = 0, ex_regWr = 0;
    logic [1:0] ex_memtoreg = '0;
    logic ex_branch_taken = 0, ex_jump_taken = 0, ex_mdu_start = 0;
    logic [2:0] ex_cp0op = '0;
    logic pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, mdu_busy;
    logic [1:0] cp0bubble;
    logic [7:0] act;

    exp_t sbq[$];
    int   n_tests = 0, n_fail = 0;
    int   mdu_rem = 0, exc_rem = 0;

    hazard_ctrl #(.MDU_CYCLES(MDU_CYCLES), .EXC_FLUSH_CYCLES(EXC_FLUSH_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ra(id_ra), .id_rb(id_rb), .id_useA(id_useA), .id_useB(id_useB),
        .ex_rw(ex_rw), .ex_regWr(ex_regWr), .ex_memtoreg(ex_memtoreg),
        .ex_branch_taken(ex_branch_taken), .ex_jump_taken(ex_jump_taken),
        .ex_mdu_start(ex_mdu_start), .ex_cp0op(ex_cp0op),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .hazard(hazard), .BranchBubble(BranchBubble), .cp0bubble(cp0bubble),
        .mdu_busy(mdu_busy)
    );

    always #5 clk = ~clk;

    assign act = {pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, cp0bubble, mdu_busy};

    function automatic stim_t idle();
        stim_t s = '0;
        s.cp0op = CP0OP_NONE;
        return s;
    endfunction

    function automatic stim_t ld_use(input logic [4:0] rw);
        stim_t s = idle();
        s.regWr = 1; s.memtoreg = MEMTOREG_LOAD; s.rw = rw; s.ra = 5'd5; s.useA = 1;
        return s;
    endfunction

    // Reference: outputs follow from how many flush/stall cycles are still owed.
    function automatic logic [7:0] model(input stim_t s);
        logic ps = 0, st = 0, fl = 0, hz = 0, bb = 0, mb = 0;
        logic [1:0] cb = 2'd0;
        logic lu, xf;
        lu = s.regWr && s.memtoreg == MEMTOREG_LOAD && s.rw != 0 &&
             ((s.useA && s.ra == s.rw) || (s.useB && s.rb == s.rw));
        xf = s.br || s.jmp;
        if (!rst_n) begin
            mdu_rem = 0; exc_rem = 0;
        end else if (exc_rem > 0) begin
            cb = 2'd1; fl = 1; hz = 1; exc_rem--;
        end else if (mdu_rem > 0) begin
            ps = 1; st = 1; hz = 1; mb = 1; mdu_rem--;
        end else if (s.cp0op == CP0OP_ERET || s.cp0op == CP0OP_SYSCALL) begin
            cb = 2'd1; fl = 1; hz = 1; exc_rem = EXC_FLUSH_CYCLES - 1;
        end else begin
            if (xf) begin bb = 1; fl = 1; end
            if (s.mdu) begin
                if (!xf) begin ps = 1; st = 1; hz = 1; mb = 1; end
                mdu_rem = MDU_CYCLES - 1;
            end else if (lu && !xf) begin
                ps = 1; st = 1; hz = 1;
            end
        end
        return {ps, st, fl, hz, bb, cb, mb};
    endfunction

    task automatic drive(input stim_t s);
        id_ra = s.ra; id_rb = s.rb; id_useA = s.useA; id_useB = s.useB;
        ex_rw = s.rw; ex_regWr = s.regWr; ex_memtoreg = s.memtoreg;
        ex_branch_taken = s.br; ex_jump_taken = s.jmp; ex_mdu_start = s.mdu;
        ex_cp0op = s.cp0op;
    endtask

    task automatic step(input string tag, input stim_t s);
        exp_t e;
        @(posedge clk); #1;
        drive(s);
        e.exp = model(s);
        e.tag = tag;
        sbq.push_back(e);
    endtask

    // Reset asserted well before the falling edge, so no clock edge intervenes.
    task automatic async_reset(input string tag);
        exp_t e;
        @(posedge clk); #3;
        drive(idle());
        rst_n = 1'b0;
        mdu_rem = 0; exc_rem = 0;
        e.exp = 8'd0; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got {ps,is,fl,hz,bb,cb,mb}=%b expected %b", e.tag, act, e.exp);
            end
            n_tests++;
            if ((ifid_stall && ifid_flush) || (pc_stall && !hazard) || cp0bubble[1]) begin
                n_fail++;
                $display("FAIL invariant_%s: got outputs %b", e.tag, act);
            end
        end
    end

    initial begin
        stim_t s;
        drive(idle());
        step("reset_idle", idle());
        release_reset();

        step("load_use", ld_use(5'd5));
        step("load_use_drop", idle());
        step("load_use_rw0", ld_use(5'd0));
        s = ld_use(5'd7); s.useA = 0; s.useB = 1; s.rb = 5'd7;
        step("load_use_rb", s);
        s = ld_use(5'd5); s.memtoreg = 2'd0;
        step("no_load_alu", s);

        s = ld_use(5'd5); s.br = 1;
        step("branch_over_lu", s);
        s = idle(); s.jmp = 1;
        step("jump", s);

        s = idle(); s.mdu = 1;
        step("mdu_issue", s);
        for (int i = 0; i < MDU_CYCLES - 1; i++) begin
            s = ld_use(5'd5); s.br = 1; s.cp0op = CP0OP_SYSCALL; s.mdu = 1;
            step($sformatf("mdu_wait%0d", i), s);
        end
        step("mdu_done", idle());

        s = idle(); s.cp0op = CP0OP_SYSCALL;
        step("syscall", s);
        step("syscall_flush", s);
        step("syscall_done", idle());

        s = idle(); s.cp0op = CP0OP_ERET; s.jmp = 1; s.mdu = 1;
        step("prio_eret", s);
        step("prio_flush", idle());
        step("prio_after", idle());

        s = idle(); s.mdu = 1; s.br = 1;
        step("mdu_xfer", s);
        for (int i = 0; i < MDU_CYCLES - 1; i++) step($sformatf("mdu_xfer_wait%0d", i), idle());
        step("mdu_xfer_done", idle());

        s = idle(); s.mdu = 1;
        step("mdu_rst_issue", s);
        step("mdu_rst_wait1", idle());
        async_reset("reset_mid_mdu");
        step("reset_held", idle());
        release_reset();
        step("post_reset_idle", idle());
        step("post_reset_lu", ld_use(5'd5));

        for (int i = 0; i < 3000; i++) begin
            s.ra = 5'($urandom_range(0, 3));
            s.rb = 5'($urandom_range(0, 3));
            s.useA = 1'($urandom);
            s.useB = 1'($urandom);
            s.rw = 5'($urandom_range(0, 3));
            s.regWr = 1'($urandom);
            s.memtoreg = 2'($urandom);
            s.br = ($urandom_range(0, 9) == 0);
            s.jmp = ($urandom_range(0, 14) == 0);
            s.mdu = ($urandom_range(0, 14) == 0);
            case ($urandom_range(0, 29))
                0: s.cp0op = CP0OP_ERET;
                1: s.cp0op = CP0OP_SYSCALL;
                2: s.cp0op = 3'b001;
                default: s.cp0op = CP0OP_NONE;
            endcase
            step("random", s);
        end

        repeat (2) @(posedge clk);
        if (sbq.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
